fact_accel: RTL and testbench

//  Memory-mapped factorial accelerator on the mips data-memory bus, downstream of the core's we_dm/alu_mult/wd_dm outputs.

---
 rtl/fact_accel_pkg.sv | 28 ++
 rtl/fact_accel_if.sv | 23 ++
 rtl/fact_accel_dp.sv | 48 ++++
 rtl/fact_accel.sv | 143 ++++++++++++++
 tb/tb_fact_accel.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fact_accel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fact_pkg
// Purpose  : Shared definitions for the factorial accelerator: FSM state
//            enum, register-map word offsets and STATUS bit positions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fact_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  // Word offsets (byte address bits [3:2])
  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_GO     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  // STATUS register bit positions
  localparam int DONE_B = 0;
  localparam int ERR_B  = 1;
  localparam int BUSY_B = 2;

endpackage
`default_nettype wire

// File: rtl/fact_accel_if.sv
`default_nettype none
// ============================================================================
// Module   : fact_accel_if
// Purpose  : Data-memory bus slice seen by the factorial accelerator.
// Signals  : we  - decoder-qualified write strobe
//            a   - word offset (byte addr[3:2])
//            wd  - write data
//            rd  - read data, combinational from a
// Modports : master (CPU/decoder side), slave (accelerator side)
// Revision : 1.0 - initial release
// ============================================================================
interface fact_accel_if #(
  parameter int WIDTH = 32
);
  logic             we;
  logic [1:0]       a;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;

  modport master (output we, output a, output wd, input  rd);
  modport slave  (input  we, input  a, input  wd, output rd);
endinterface
`default_nettype wire

// File: rtl/fact_accel_dp.sv
`default_nettype none
// ============================================================================
// Module   : fact_dp
// Purpose  : Factorial datapath: down-counter cnt, running product prod and
//            the cnt > 1 compare that tells the FSM when to stop.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            load       - capture n into cnt and set prod to 1
//            step       - prod <= prod*cnt (truncated), cnt <= cnt-1
//            n          - operand captured on load
//            prod       - running product
//            cnt_gt1    - cnt > 1
// Revision : 1.0 - initial release
// ============================================================================
module fact_dp #(
  parameter int WIDTH  = 32,
  parameter int N_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [N_BITS-1:0] n,
  output logic [WIDTH-1:0]  prod,
  output logic              cnt_gt1
);

  logic [N_BITS-1:0] cnt;
  logic [WIDTH-1:0]  mul;

  // Unsigned WIDTH x N_BITS multiply, kept to WIDTH bits
  assign mul     = prod * WIDTH'(cnt);
  assign cnt_gt1 = (cnt > N_BITS'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      prod <= '0;
    end else if (load) begin
      cnt  <= n;
      prod <= WIDTH'(1);
    end else if (step) begin
      cnt  <= cnt - N_BITS'(1);
      prod <= mul;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fact_accel.sv
`default_nettype none
// ============================================================================
// Module   : fact_accel
// Purpose  : Memory-mapped iterative factorial accelerator (one multiply per
//            clock). Software writes N, pulses GO, polls STATUS, reads RESULT.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - fact_accel_if.slave (we, a, wd in; rd out)
//            irq  - completion pulse, only when FACT_IRQ_EN is defined
// Macro    : FACT_IRQ_EN - adds the irq output and its pulse logic
// Revision : 1.0 - initial release
// ============================================================================
module fact_accel
  import fact_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int N_BITS = 4,
  parameter int MAX_N  = 12
) (
  input  logic         clk,
  input  logic         rst,
  fact_accel_if.slave  bus
`ifdef FACT_IRQ_EN
  ,
  output logic         irq
`endif
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_CALC = CALC;

  logic [0:0]        state;
  logic [N_BITS-1:0] n_reg;
  logic              busy;
  logic              err;
  logic              done;
  logic [WIDTH-1:0]  result;

  logic              go_wr;
  logic              n_wr;
  logic              n_too_big;
  logic              load;
  logic              step;
  logic              done_set;
  logic [WIDTH-1:0]  prod;
  logic              cnt_gt1;

  assign go_wr     = bus.we && (bus.a == ADDR_GO) && bus.wd[0];
  assign n_wr      = bus.we && (bus.a == ADDR_N);
  assign n_too_big = (32'(n_reg) > 32'(MAX_N));

  assign load      = (state == ST_IDLE) && go_wr && !n_too_big;
  assign step      = (state == ST_CALC) && cnt_gt1;
  // Every edge that sets done: an ERR rejection or a normal finish
  assign done_set  = ((state == ST_IDLE) && go_wr && n_too_big) ||
                     ((state == ST_CALC) && !cnt_gt1);

  fact_dp #(
    .WIDTH  (WIDTH),
    .N_BITS (N_BITS)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .n       (n_reg),
    .prod    (prod),
    .cnt_gt1 (cnt_gt1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      n_reg  <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      // N stays writable while busy; the datapath already holds its copy
      if (n_wr) begin
        n_reg <= bus.wd[N_BITS-1:0];
      end
      case (state)
        ST_IDLE: begin
          if (go_wr) begin
            if (n_too_big) begin
              err    <= 1'b1;
              done   <= 1'b1;
              result <= '0;
            end else begin
              busy  <= 1'b1;
              done  <= 1'b0;
              err   <= 1'b0;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (!cnt_gt1) begin
            result <= prod;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read mux; GO reads back as zero
  always_comb begin
    bus.rd = '0;
    case (bus.a)
      ADDR_N:      bus.rd = WIDTH'(n_reg);
      ADDR_STATUS: begin
        bus.rd[DONE_B] = done;
        bus.rd[ERR_B]  = err;
        bus.rd[BUSY_B] = busy;
      end
      ADDR_RESULT: bus.rd = result;
      default:     bus.rd = '0;
    endcase
  end

`ifdef FACT_IRQ_EN
  // done is high after the done_set edge; irq fires on the following edge
  logic done_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_evt <= 1'b0;
      irq      <= 1'b0;
    end else begin
      done_evt <= done_set;
      irq      <= done_evt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fact_accel.sv
`default_nettype none
// ============================================================================
// Module   : tb_fact_accel
// Purpose  : Self-checking bench for fact_accel. A behavioural model tracks
//            the register map from software-visible rules; a negedge process
//            compares rd (and irq) against it every cycle, and directed
//            vectors pin hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fact_accel;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  fact_accel_if #(.WIDTH(32)) bus ();

`ifdef FACT_IRQ_EN
  logic irq;
`endif

  fact_accel #(
    .WIDTH  (32),
    .N_BITS (4),
    .MAX_N  (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FACT_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  bit          started  = 1'b0;
  logic [3:0]  m_n      = '0;
  bit          m_busy   = 1'b0;
  bit          m_err    = 1'b0;
  bit          m_done   = 1'b0;
  logic [31:0] m_result = '0;
  logic [3:0]  m_cap    = '0;
  int          m_remain = 0;
  bit          m_ev     = 1'b0;
  bit          m_irq    = 1'b0;
  int          irq_count = 0;

  function automatic logic [31:0] fact(input int k);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 2; i <= k; i++) p = p * 32'(i);
    return p;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] addr);
    case (addr)
      2'd0:    return {28'd0, m_n};
      2'd2:    return {29'd0, m_busy, m_err, m_done};
      2'd3:    return m_result;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit         was_busy;
    bit         dset;
    logic [3:0] n_prev;
    started = 1'b1;
    dset    = 1'b0;
    if (rst) begin
      m_n = '0; m_busy = 0; m_err = 0; m_done = 0; m_result = '0;
      m_remain = 0; m_ev = 0; m_irq = 0;
    end else begin
      was_busy = m_busy;
      n_prev   = m_n;
      m_irq    = m_ev;
      if (m_busy) begin
        m_remain--;
        if (m_remain == 0) begin
          m_busy = 0; m_done = 1; m_result = fact(int'(m_cap)); dset = 1;
        end
      end
      if (bus.we && bus.a == 2'd0) m_n = bus.wd[3:0];
      if (bus.we && bus.a == 2'd1 && bus.wd[0] && !was_busy) begin
        if (n_prev > 4'd12) begin
          m_err = 1; m_done = 1; m_result = '0; dset = 1;
        end else begin
          m_busy = 1; m_done = 0; m_err = 0; m_cap = n_prev;
          m_remain = (n_prev == 4'd0) ? 1 : int'(n_prev);
        end
      end
      m_ev = dset;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    if (started) begin
      exp_rd = model_rd(bus.a);
      vectors++;
      if (bus.rd !== exp_rd) begin
        miscompares++;
        $display("FAIL model_rd a=%0d: got %0d expected %0d at %0t", bus.a, bus.rd, exp_rd, $time);
      end
`ifdef FACT_IRQ_EN
      vectors++;
      if (irq !== m_irq) begin
        miscompares++;
        $display("FAIL model_irq: got %b expected %b at %0t", irq, m_irq, $time);
      end
      if (irq === 1'b1) irq_count++;
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] d);
    bus.a  = addr;
    bus.wd = d;
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
    bus.wd = '0;
  endtask

  task automatic chk(input logic [1:0] addr, input logic [31:0] exp_v, input string nm);
    bus.a = addr;
    #1;
    vectors++;
    if (bus.rd !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, bus.rd, exp_v);
    end
  endtask

  task automatic wait_done(input int budget, input string nm);
    bit ok;
    ok    = 1'b0;
    bus.a = 2'd2;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (bus.rd[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: done not seen within %0d cycles (got 0 expected 1)", nm, budget);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.we = 1'b0;
    bus.a  = 2'd0;
    bus.wd = '0;
    rst    = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // 1. reset values
    chk(2'd0, 32'd0, "reset_N");
    chk(2'd1, 32'd0, "reset_GO");
    chk(2'd2, 32'd0, "reset_STATUS");
    chk(2'd3, 32'd0, "reset_RESULT");

    // 2. 5! with exact latency
    wr(2'd0, 32'd5);
    chk(2'd0, 32'd5, "N_readback");
    wr(2'd1, 32'd1);
    chk(2'd2, 32'd4, "n5_busy_first");
    repeat (4) tick();
    chk(2'd2, 32'd4, "n5_busy_edge4");
    tick();
    chk(2'd2, 32'd1, "n5_done_edge5");
    chk(2'd3, 32'd120, "n5_result");

    // 3. boundaries 0, 1, MAX_N
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd1);
    tick();
    chk(2'd2, 32'd1, "n0_done");
    chk(2'd3, 32'd1, "n0_result");
    wr(2'd0, 32'd1);
    wr(2'd1, 32'd1);
    tick();
    chk(2'd3, 32'd1, "n1_result");
    wr(2'd0, 32'd12);
    wr(2'd1, 32'd1);
    repeat (11) tick();
    chk(2'd2, 32'd4, "n12_busy_edge11");
    tick();
    chk(2'd2, 32'd1, "n12_done");
    chk(2'd3, 32'd479001600, "n12_result");

    // 4. out of range, then recovery
    wr(2'd0, 32'd13);
    wr(2'd1, 32'd1);
    chk(2'd2, 32'd3, "n13_err_done");
    chk(2'd3, 32'd0, "n13_result");
    wr(2'd3, 32'hDEAD_BEEF);
    chk(2'd3, 32'd0, "result_write_ignored");
    wr(2'd0, 32'd3);
    wr(2'd1, 32'd1);
    chk(2'd2, 32'd4, "err_cleared");
    wait_done(10, "n3_wait");
    chk(2'd3, 32'd6, "n3_result");

    // 5. N and GO written while busy
    wr(2'd0, 32'd6);
    wr(2'd1, 32'd1);
    repeat (2) tick();
    wr(2'd0, 32'd2);
    wr(2'd1, 32'd1);
    chk(2'd2, 32'd4, "go_while_busy");
    wait_done(20, "n6_wait");
    chk(2'd3, 32'd720, "n6_result");
    chk(2'd0, 32'd2, "N_updated_busy");
    wr(2'd1, 32'd1);
    wait_done(10, "n2_wait");
    chk(2'd3, 32'd2, "n2_result");

    // 6. reset mid-run
    wr(2'd0, 32'd10);
    wr(2'd1, 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(2'd0, 32'd0, "abort_N");
    chk(2'd2, 32'd0, "abort_STATUS");
    chk(2'd3, 32'd0, "abort_RESULT");
    repeat (15) tick();
    chk(2'd2, 32'd0, "abort_stays_idle");
    wr(2'd0, 32'd4);
    wr(2'd1, 32'd1);
    wait_done(10, "n4_wait");
    chk(2'd3, 32'd24, "n4_result");
    repeat (4) tick();

`ifdef FACT_IRQ_EN
    // completions: 5,0,1,12,13(err),3,6,2,4
    vectors++;
    if (irq_count != 9) begin
      miscompares++;
      $display("FAIL irq_count: got %0d expected 9", irq_count);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
